// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
interface bcd_serial_addsub_if #(
   parameter int unsigned N_DIGITS = 4
);
   localparam int unsigned W = 4 * N_DIGITS;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;
   logic         busy;
   logic         done;

   // Requester side: drives operands and start, observes the result.
   modport master (
      output start, sub, a, b,
      input  sum, cout, err, busy, done
   );

   // Arithmetic unit side.
   modport slave (
      input  start, sub, a, b,
      output sum, cout, err, busy, done
   );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Packed-BCD adder/subtractor, one digit per clock, least significant digit first.
// Subtraction uses the 9's complement of B with an initial carry of 1 (10's complement).
module bcd_serial_addsub #(
   parameter int unsigned N_DIGITS = 4
) (
   input logic                clk_i,
   input logic                rst_b_i,
   bcd_serial_addsub_if.slave bus
);
   localparam int unsigned W    = 4 * N_DIGITS;
   localparam int unsigned CntW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N_DIGITS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sub_q, sub_d, carry_q, carry_d, ierr_q, ierr_d;
   logic            cout_q, cout_d, err_q, err_d, done_q, done_d;

   logic            in_bad;
   logic [3:0]      da, db, dig;
   logic [4:0]      t;
   logic            dcarry;

   // Flag any non-decimal nibble on the incoming operands.
   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // Single-digit decimal add on the lowest nibble of the shifting operand registers.
   always_comb begin
      da     = a_q[3:0];
      db     = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
      // Full 5-bit sum so the >9 test sees the true value.
      t      = {1'b0, da} + {1'b0, db} + {4'b0000, carry_q};
      dcarry = (t > 5'd9);
      dig    = dcarry ? 4'(t - 5'd10) : t[3:0];
   end

   // FSM next state and datapath updates.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      ierr_d  = ierr_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               a_d     = bus.a;
               b_d     = bus.b;
               sub_d   = bus.sub;
               carry_d = bus.sub;
               cnt_d   = '0;
               ierr_d  = in_bad;
            end
         end
         StRun: begin
            // Operands shift down so the current digit is always at [3:0];
            // result digits enter at the top and land in place after N_DIGITS shifts.
            a_d              = a_q >> 4;
            b_d              = b_q >> 4;
            res_d            = res_q >> 4;
            res_d[W-1 -: 4]  = dig;
            carry_d          = dcarry;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == LastCnt) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            done_d  = 1'b1;
            err_d   = ierr_q;
            sum_d   = ierr_q ? '0 : res_q;
            cout_d  = ierr_q ? 1'b0 : carry_q;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         ierr_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ierr_q  <= ierr_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;
   assign bus.done = done_q;
   // Busy spans RUN and DONE, dropping as the registered done pulse appears.
   assign bus.busy = (state_q != StIdle);
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub with a scoreboard of expected results.
module tb_bcd_serial_addsub;
   localparam int unsigned N = 4;
   localparam int unsigned Latency = N + 1;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        err;
      string       tag;
   } exp_t;
   exp_t sb[$];

   bcd_serial_addsub_if #(.N_DIGITS(N)) bus ();

   bcd_serial_addsub #(.N_DIGITS(N)) dut (
      .clk_i   (clk),
      .rst_b_i (rst_b),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int          x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference model: plain integer arithmetic modulo 10^4.
   task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input string tag);
      exp_t e;
      int   ia, ib;
      logic bad_in = 1'b0;
      for (int i = 0; i < 4; i++)
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
      ia = bcd2int(a);
      ib = bcd2int(b);
      e.tag = tag;
      if (bad_in) begin
         e.sum = 16'h0; e.cout = 1'b0; e.err = 1'b1;
      end else if (!sub) begin
         e.sum = int2bcd((ia + ib) % 10000); e.cout = (ia + ib) >= 10000; e.err = 1'b0;
      end else if (ia >= ib) begin
         e.sum = int2bcd(ia - ib); e.cout = 1'b1; e.err = 1'b0;
      end else begin
         e.sum = int2bcd(10000 - (ib - ia)); e.cout = 1'b0; e.err = 1'b0;
      end
      sb.push_back(e);
   endtask

   // Present one request for a single cycle; returns just after the accepting edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = 1'($urandom);
   endtask

   // Wait (bounded) for done, check latency, result against the scoreboard and pulse width.
   task automatic collect(input int edges_before);
      int   n = edges_before;
      exp_t e;
      while (bus.done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      e = sb.pop_front();
      chk({e.tag, " done"}, 32'(bus.done), 32'd1);
      chk({e.tag, " latency"}, 32'(n), 32'(Latency));
      chk({e.tag, " sum"}, 32'(bus.sum), 32'(e.sum));
      chk({e.tag, " cout"}, 32'(bus.cout), 32'(e.cout));
      chk({e.tag, " err"}, 32'(bus.err), 32'(e.err));
      chk({e.tag, " busy@done"}, 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk({e.tag, " pulse width"}, 32'(bus.done), 32'd0);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input string tag);
      push_exp(a, b, sub, tag);
      issue(a, b, sub);
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      collect(0);
   endtask

   initial begin
      int pulses;
      bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
      #12;
      chk("rst sum", 32'(bus.sum), 32'd0);
      chk("rst cout", 32'(bus.cout), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst err", 32'(bus.err), 32'd0);
      @(negedge clk); rst_b = 1'b1;

      run_op(16'h1234, 16'h5678, 1'b0, "add1234+5678");
      run_op(16'h9999, 16'h0001, 1'b0, "add9999+0001");
      run_op(16'h9876, 16'h5432, 1'b0, "add9876+5432");
      run_op(16'h5000, 16'h1234, 1'b1, "sub5000-1234");
      run_op(16'h0001, 16'h0002, 1'b1, "sub0001-0002");
      run_op(16'h4321, 16'h4321, 1'b1, "sub4321-4321");
      run_op(16'h00A0, 16'h0001, 1'b0, "err00A0");
      run_op(16'h0042, 16'h0058, 1'b0, "clr_err");

      // Second start during RUN must be ignored.
      push_exp(16'h1111, 16'h1111, 1'b0, "ignore2nd");
      issue(16'h1111, 16'h1111, 1'b0);
      @(posedge clk); #1;
      issue(16'h9999, 16'h9999, 1'b1);
      collect(2);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) pulses++;
      end
      chk("ignore2nd extra done", 32'(pulses), 32'd0);
      chk("ignore2nd sum held", 32'(bus.sum), 32'h2222);

      // Asynchronous reset while digit 2 is in progress.
      issue(16'h2345, 16'h1111, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_b = 1'b0;
      #1;
      chk("midrst sum", 32'(bus.sum), 32'd0);
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst done", 32'(bus.done), 32'd0);
      chk("midrst cout", 32'(bus.cout), 32'd0);
      @(negedge clk); rst_b = 1'b1;
      run_op(16'h2345, 16'h1111, 1'b0, "after_rst");
      run_op(16'h0000, 16'h0000, 1'b1, "sub0-0");

      chk("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
